// File: rtl/imem_dump_streamer.sv
// Streams a block of instruction-memory words out as a little-endian byte
// stream over a valid/ready handshake; one read per word, four bytes per read.
module imem_dump_streamer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       shift_q;

    logic load, capture, xfer, next_word, last_word;

    // count_q is one bit wider than word_idx so a full-memory dump ends at
    // the top address instead of wrapping.
    assign last_word   = ({1'b0, word_idx} == (count_q - {{ADDR_W{1'b0}}, 1'b1}));
    assign mem_rd_addr = word_idx;
    assign byte_out    = shift_q[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        next_word  = 1'b0;
        mem_rd_en  = 1'b0;
        byte_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (word_count != '0) begin
                        load     = 1'b1;
                        state_nx = READ;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            READ: begin
                mem_rd_en = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                capture  = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
                    xfer = 1'b1;
                    if (byte_idx == 2'd3) begin
                        if (last_word) begin
                            state_nx = DONE;
                        end else begin
                            next_word = 1'b1;
                            state_nx  = READ;
                        end
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            shift_q  <= '0;
        end else begin
            if (load) begin
                count_q  <= word_count;
                word_idx <= '0;
                byte_idx <= '0;
            end
            if (capture) begin
                shift_q <= mem_rd_data;
            end
            if (xfer) begin
                shift_q  <= {8'h00, shift_q[31:8]};
                byte_idx <= byte_idx + 2'd1;
            end
            if (next_word) begin
                word_idx <= word_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: doc/imem_dump_streamer.md
IMEM_DUMP_STREAMER -- requirements
Module: imem_dump_streamer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width (256 words).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle dump request, honoured only in IDLE.
REQ-005 The block SHALL have port word_count, input, ADDR_W+1 bits, the number of words to dump (0..2^ADDR_W), latched when start is accepted.
REQ-006 The block SHALL have port mem_rd_en, output, 1 bit, the instruction-memory read strobe.
REQ-007 The block SHALL have port mem_rd_addr, output, ADDR_W bits, the instruction-memory word address.
REQ-008 The block SHALL have port mem_rd_data, input, 32 bits, the read data, valid in the cycle after mem_rd_en.
REQ-009 The block SHALL have port byte_out, output, 8 bits, the serialized byte.
REQ-010 The block SHALL have port byte_valid, output, 1 bit, which is high when byte_out holds a byte.
REQ-011 The block SHALL have port byte_ready, input, 1 bit, the sink's acceptance; a transfer occurs when byte_valid and byte_ready are both high at a clock edge.
REQ-012 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, READ, WAIT, SEND and DONE.
REQ-015 In IDLE with start=1 and word_count>0: latch word_count, clear word index and byte index, go to READ.
REQ-016 In IDLE with start=1 and word_count=0: go directly to DONE; no memory read and no byte issued.
REQ-017 In READ: mem_rd_en=1 for exactly one cycle and mem_rd_addr=word index, then go to WAIT.
REQ-018 In WAIT: capture mem_rd_data into a 32-bit shift register at the clock edge, then go to SEND.
REQ-019 In SEND: byte_valid=1 and byte_out=shift[7:0], so bytes leave little-endian (bits [7:0] first, [31:24] last).
REQ-020 While byte_valid=1 and byte_ready=0, byte_out SHALL hold stable and the state SHALL not change.
REQ-021 On each transfer: shift right by 8 and increment the byte index (mod 4).
REQ-022 On the 4th transfer of a word: go to DONE if this was the last word (index = latched count-1); otherwise increment the word index and go to READ.
REQ-023 In DONE: done=1 for one cycle, then go to IDLE.
REQ-024 start SHALL be ignored while busy=1; the latched count SHALL be unaffected by later word_count changes.
REQ-025 Timing with start accepted at edge k: READ is in cycle k+1, WAIT in k+2, and the first byte_valid in k+3.
REQ-026 With byte_ready held high, each word SHALL take exactly 6 cycles; N words SHALL take 6N cycles plus 1 DONE cycle.
REQ-027 word_count=2^ADDR_W SHALL dump addresses 0..2^ADDR_W-1 with no address wrap and no extra read.
REQ-028 mem_rd_en SHALL be 0 in all states except READ.
REQ-029 byte_valid SHALL be 0 in all states except SEND.

Reset
REQ-030 reset=1 SHALL force IDLE at the next edge, including mid-dump; any partial byte sequence is abandoned and no done pulse is generated.
REQ-031 After reset: mem_rd_en=0, mem_rd_addr=0, byte_out=0, byte_valid=0, busy=0, done=0, shift register=0, indices=0.
REQ-032 reset SHALL have priority over start in the same cycle.

Verification
REQ-033 Memory word 0 = 32'h11223344, start with word_count=1, ready held high -> bytes 44,33,22,11 in cycles k+3..k+6, done in k+7, busy low from k+8.
REQ-034 Words 0..2 = 32'h03020100, 32'h07060504, 32'h0B0A0908, count=3 -> bytes 00..0B in order, read addresses 0,1,2 one each, done after 19 cycles.
REQ-035 count=1 with ready low for 5 cycles after the first byte_valid -> byte_out stays 8'h44 and stable, then the sequence completes unchanged.
REQ-036 count=0 -> no mem_rd_en, no byte_valid, done pulse in cycle k+1.
REQ-037 reset asserted during the 2nd byte of word 1 (count=4) -> next cycle all outputs are at reset values; a new start with count=1 dumps word 0 correctly.
REQ-038 count=256 with ADDR_W=8 -> 1024 bytes, last read address 8'hFF, exactly 256 read strobes; a start pulse mid-dump has no effect.
